// File: rtl/rvecc_err_handler_if.sv
// Scrub writeback channel from the ECC error handler to the DCCM/ICCM array.
// The handler drives the request side; the array drives wb_ready.
interface rvecc_err_handler_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [31:0]           wb_data;
  logic [6:0]            wb_ecc;

  modport master (output wb_valid, wb_addr, wb_data, wb_ecc, input wb_ready);
  modport slave  (input wb_valid, wb_addr, wb_data, wb_ecc, output wb_ready);
endinterface

// File: rtl/rvecc_err_handler.sv
// Post-SECDED error handler: error statistics, sticky interrupts and a
// single-entry scrub writeback of corrected words.
module rvecc_err_handler #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  single_ecc_error,
  input  logic                  double_ecc_error,
  input  logic [31:0]           corr_data,
  input  logic [6:0]            corr_ecc,
  rvecc_err_handler_if.master   wb,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sb_count,
  output logic [CNT_WIDTH-1:0]  db_count,
  input  logic [CNT_WIDTH-1:0]  sb_thresh,
  output logic                  sb_irq,
  output logic                  db_irq,
  output logic                  sb_drop,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  clr
);

  typedef enum logic {IDLE = 1'b0, WB = 1'b1} state_t;

  state_t                state, state_n;
  logic                  sb_ev, db_ev, xfer, capture, drop;
  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] wb_addr_p0;
  logic [31:0]           wb_data_p0;
  logic [6:0]            wb_ecc_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A double flag dominates: a read flagged both ways is uncorrectable.
  assign sb_ev = rd_valid & single_ecc_error & ~double_ecc_error;
  assign db_ev = rd_valid & double_ecc_error;

  assign vld_p0 = (state == WB);
  assign xfer   = vld_p0 & wb.wb_ready;

  always_comb begin
    state_n = state;
    capture = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (sb_ev) begin
          capture = 1'b1;
          state_n = WB;
        end
      end
      WB: begin
        if (xfer) begin
          capture = sb_ev;
          state_n = sb_ev ? WB : IDLE;
        end else begin
          drop = sb_ev;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: writeback request register, held until the array accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wb_addr_p0 <= '0;
      wb_data_p0 <= '0;
      wb_ecc_p0  <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        wb_addr_p0 <= rd_addr;
        wb_data_p0 <= corr_data;
        wb_ecc_p0  <= corr_ecc;
      end
    end
  end

  // clr wins over any same-cycle increment or flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_count <= '0;
      db_count <= '0;
      sb_irq   <= 1'b0;
      db_irq   <= 1'b0;
      sb_drop  <= 1'b0;
      err_addr <= '0;
    end else if (clr) begin
      sb_count <= '0;
      db_count <= '0;
      sb_irq   <= 1'b0;
      db_irq   <= 1'b0;
      sb_drop  <= 1'b0;
      err_addr <= '0;
    end else begin
      if (sb_ev) sb_count <= sat_inc(sb_count);
      if (db_ev) db_count <= sat_inc(db_count);
      if ((sb_thresh != '0) && (sb_count >= sb_thresh)) sb_irq <= 1'b1;
      if (db_ev) db_irq <= 1'b1;
      if (drop) sb_drop <= 1'b1;
      if (sb_ev | db_ev) err_addr <= rd_addr;
    end
  end

  assign wb.wb_valid = vld_p0;
  assign wb.wb_addr  = wb_addr_p0;
  assign wb.wb_data  = wb_data_p0;
  assign wb.wb_ecc   = wb_ecc_p0;
  assign busy        = vld_p0;

endmodule
